// File: rtl/ctrl_edicion_campos.sv
// ctrl_edicion_campos: edit-mode controller that picks the adjustable BCD field and issues up/down/blink signals.
module ctrl_edicion_campos #(
  parameter int TIMEOUT_CYC = 1500000000,
  parameter int BLINK_CYC   = 25000000,
  parameter int TO_W        = 31,
  parameter int BL_W        = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] grp_sel,
  input  logic       btn_prog,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_mode,
  output logic       blink
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYC - 1);
  typedef enum logic {IDLE, EDIT} state_t;
  state_t state, state_nx;
  logic prog_q, left_q, right_q;
  logic prog_e, left_e, right_e, move, enter;
  logic [1:0] grp_lat, cursor;
  logic [TO_W-1:0] to_cnt;
  logic [BL_W-1:0] bl_cnt;
  assign prog_e  = btn_prog & ~prog_q;
  assign left_e  = btn_left & ~left_q;
  assign right_e = btn_right & ~right_q;
  // opposite edges on the same clock cancel and count as no move
  assign move  = left_e ^ right_e;
  assign enter = (state == IDLE) && (state_nx == EDIT);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (prog_e ? EDIT : IDLE)
                               : ((prog_e || to_cnt == TO_LAST) ? IDLE : EDIT);
  always_comb begin
    edit_mode = (state == EDIT);
    en_count  = !edit_mode        ? 4'd0 :
                grp_lat == 2'd0   ? 4'd1 + {2'b00, cursor} :
                grp_lat == 2'd1   ? 4'd4 + {2'b00, cursor} :
                cursor == 2'd2    ? 4'd7 : 4'd8 + {2'b00, cursor};
    enUP      = edit_mode & btn_up & ~btn_down;
    enDOWN    = edit_mode & btn_down & ~btn_up;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {prog_q, left_q, right_q} <= 3'b000;
      grp_lat <= 2'd0;
      cursor  <= 2'd0;
      to_cnt  <= '0;
      bl_cnt  <= '0;
      blink   <= 1'b0;
    end else begin
      {prog_q, left_q, right_q} <= {btn_prog, btn_left, btn_right};
      if (enter) begin
        grp_lat <= (grp_sel == 2'd3) ? 2'd0 : grp_sel;
        cursor  <= 2'd0;
        to_cnt  <= '0;
        bl_cnt  <= '0;
        blink   <= 1'b1;
      end else if (state_nx == IDLE) begin
        to_cnt <= '0;
        bl_cnt <= '0;
        blink  <= 1'b0;
      end else begin
        to_cnt <= (left_e | right_e | btn_up | btn_down) ? '0 : to_cnt + 1'b1;
        if (move) begin
          cursor <= right_e ? (cursor == 2'd2 ? 2'd0 : cursor + 2'd1)
                            : (cursor == 2'd0 ? 2'd2 : cursor - 2'd1);
          bl_cnt <= '0;
          blink  <= 1'b1;
        end else if (bl_cnt == BL_LAST) begin
          bl_cnt <= '0;
          blink  <= ~blink;
        end else bl_cnt <= bl_cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_ctrl_edicion_campos.sv
// tb_ctrl_edicion_campos: directed plus randomized checks of the edit controller against a cycle-stamp model.
module tb_ctrl_edicion_campos;
  localparam int TIMEOUT = 20;
  localparam int BLINK   = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] grp_sel = 2'd2;
  logic btn_prog = 0, btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
  logic [3:0] en_count;
  logic enUP, enDOWN, edit_mode, blink;
  int errors = 0, checks = 0;
  int m_edit = 0, m_grp = 0, m_cur = 0, cyc = 0, last_act = 0, last_bl = 0;
  bit pp = 0, pl = 0, pr = 0;
  int tbl [3][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{8, 9, 7}};

  ctrl_edicion_campos #(.TIMEOUT_CYC(TIMEOUT), .BLINK_CYC(BLINK), .TO_W(5), .BL_W(3)) dut (
    .clk(clk), .reset(reset), .grp_sel(grp_sel), .btn_prog(btn_prog), .btn_left(btn_left),
    .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down), .en_count(en_count),
    .enUP(enUP), .enDOWN(enDOWN), .edit_mode(edit_mode), .blink(blink));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic move_cur(input bit right, input int exp);
    if (right) btn_right = 1; else btn_left = 1;
    tick();
    chk(right ? "cursor_right" : "cursor_left", en_count, exp);
    btn_right = 0;
    btn_left  = 0;
    tick();
  endtask

  // reference: edit episodes tracked by the clock index of the last activity and last blink restart
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_edit <= 0; m_grp <= 0; m_cur <= 0; cyc <= 0; last_act <= 0; last_bl <= 0;
      pp <= 0; pl <= 0; pr <= 0;
    end else begin
      cyc <= cyc + 1;
      pp <= btn_prog; pl <= btn_left; pr <= btn_right;
      if (m_edit == 0) begin
        if (btn_prog && !pp) begin
          m_edit <= 1; m_grp <= (grp_sel == 2'd3) ? 0 : int'(grp_sel); m_cur <= 0;
          last_act <= cyc + 1; last_bl <= cyc + 1;
        end
      end else if ((btn_prog && !pp) || (cyc + 1 - last_act == TIMEOUT)) m_edit <= 0;
      else begin
        if ((btn_left && !pl) || (btn_right && !pr) || btn_up || btn_down) last_act <= cyc + 1;
        if ((btn_left && !pl) != (btn_right && !pr)) begin
          m_cur <= (m_cur + ((btn_right && !pr) ? 1 : 2)) % 3;
          last_bl <= cyc + 1;
        end
      end
    end

  always @(negedge clk)
    if (!reset) begin
      chk("edit_mode", edit_mode, m_edit);
      chk("en_count", en_count, m_edit != 0 ? tbl[m_grp][m_cur] : 0);
      chk("enUP", enUP, int'(m_edit != 0 && btn_up && !btn_down));
      chk("enDOWN", enDOWN, int'(m_edit != 0 && btn_down && !btn_up));
      chk("blink", blink, m_edit != 0 ? int'(((cyc - last_bl) / BLINK) % 2 == 0) : 0);
    end

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_edit", edit_mode, 0);
    chk("rst_en", en_count, 0);
    chk("rst_blink", blink, 0);
    reset = 0;
    tick();
    btn_prog = 1;
    tick();
    chk("enter_edit", edit_mode, 1);
    chk("enter_en", en_count, 8);
    chk("enter_blink", blink, 1);
    btn_prog = 0;
    move_cur(1, 9); move_cur(1, 7); move_cur(1, 8); move_cur(0, 7);
    move_cur(1, 8); move_cur(1, 9);
    btn_up = 1;
    repeat (10) begin
      tick();
      chk("hold_up", enUP, 1);
      chk("hold_up_down", enDOWN, 0);
    end
    btn_down = 1; #1;
    chk("both_up", enUP, 0);
    chk("both_down", enDOWN, 0);
    btn_up = 0; #1;
    chk("only_down", enDOWN, 1);
    btn_down = 0;
    n = 0;
    while (edit_mode && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, 20);
    chk("timeout_en", en_count, 0);
    grp_sel = 0;
    btn_prog = 1;
    tick();
    btn_prog = 0;
    chk("grp0_en", en_count, 1);
    for (int i = 1; i <= 34; i++) begin
      if (i == 15) btn_right = 1;
      if (i == 5) grp_sel = 1;
      tick();
      btn_right = 0;
      if (i == 3) chk("blink_on", blink, 1);
      if (i == 4) chk("blink_off", blink, 0);
      if (i == 8) chk("blink_on2", blink, 1);
      if (i == 10) chk("grp_frozen", en_count, 1);
      if (i == 15) chk("moved_en", en_count, 2);
      if (i == 16) chk("blink_restart", blink, 1);
      if (i == 34) chk("postponed_stay", edit_mode, 1);
    end
    tick();
    chk("postponed_exit", edit_mode, 0);
    grp_sel = 0;
    btn_prog = 1; tick(); btn_prog = 0; tick();
    chk("reenter_g0", en_count, 1);
    btn_prog = 1; tick(); btn_prog = 0;
    chk("prog_exit", edit_mode, 0);
    grp_sel = 1;
    tick();
    btn_prog = 1; tick(); btn_prog = 0;
    chk("reenter_g1", en_count, 4);
    btn_up = 1;
    tick();
    chk("pre_rst_up", enUP, 1);
    #1 reset = 1;
    #1;
    chk("arst_edit", edit_mode, 0);
    chk("arst_en", en_count, 0);
    chk("arst_up", enUP, 0);
    chk("arst_blink", blink, 0);
    tick();
    reset = 0;
    btn_up = 0;
    repeat (5) begin
      tick();
      chk("stay_idle", edit_mode, 0);
    end
    for (int b = 0; b < 15; b++) begin
      int act;
      act = $urandom_range(1, 8);
      repeat (200) begin
        if ($urandom_range(0, 59) == 0) btn_prog = ~btn_prog;
        btn_left  = ($urandom_range(0, 3 * act) == 0);
        btn_right = ($urandom_range(0, 3 * act) == 0);
        if ($urandom_range(0, 4 * act) == 0) btn_up = ~btn_up;
        if ($urandom_range(0, 4 * act) == 0) btn_down = ~btn_down;
        grp_sel = 2'($urandom_range(0, 3));
        tick();
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ctrl_edicion_campos.md
Name: ctrl_edicion_campos

Overview:
- Edit-mode controller for the clock/date/timer BCD counters.
- Turns debounced push-button levels into:
  - the 4-bit field-select code (en_count) that all two-digit adjust counters compare against;
  - enUP/enDOWN level requests;
  - a cursor blink signal for the display mux.
- Sits between the debouncers and the counter bank; exactly one counter field is adjustable at any time.

Parameters:
- TIMEOUT_CYC, 1500000000, idle clocks in EDIT with no button activity before automatic exit (15 s at 100 MHz).
- BLINK_CYC, 25000000, clocks per blink half-period (2 Hz blink at 100 MHz).
- TO_W, 31, width of timeout counter (must hold TIMEOUT_CYC).
- BL_W, 25, width of blink counter (must hold BLINK_CYC).

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- grp_sel  in  2  group to edit: 0 time, 1 date, 2 timer, 3 reserved (treated as 0)
- btn_prog  in  1  debounced level; rising edge enters or leaves edit mode
- btn_left  in  1  debounced level; rising edge moves cursor left
- btn_right  in  1  debounced level; rising edge moves cursor right
- btn_up  in  1  debounced level; held = increment request
- btn_down  in  1  debounced level; held = decrement request
- en_count  out  4  active field code, 0 = none
- enUP  out  1  increment request level
- enDOWN  out  1  decrement request level
- edit_mode  out  1  1 while in EDIT
- blink  out  1  cursor blink phase, 1 = digits visible

Behaviour:
- Reset value of every register and output is 0. State = IDLE, cursor = 0, grp_lat = 0, blink = 0.
- Edge detect: registered copies of btn_prog, btn_left and btn_right. An edge is a level 1 with a previous value of 0, so at most one event per press. Copies reset to 0, so a button held through reset release produces an edge on the first clock.
- FSM states are IDLE and EDIT.
- IDLE -> EDIT on prog edge:
  - grp_lat <= grp_sel (3 maps to 0);
  - cursor <= 0;
  - timeout counter cleared;
  - blink counter cleared and blink <= 1.
- EDIT -> IDLE, whichever comes first:
  - prog edge;
  - timeout counter reaching TIMEOUT_CYC-1.
- grp_sel is ignored while in EDIT; the group is frozen until exit.
- Cursor is 0..2 within the group:
  - right edge: cursor+1, with 2 wrapping to 0;
  - left edge: cursor-1, with 0 wrapping to 2;
  - simultaneous left and right edges: cursor unchanged;
  - cursor edges in IDLE are ignored.
- Field code, combinational from state, grp_lat and cursor. en_count = 0 in IDLE. In EDIT:
  - group 0 (time): 1 HH, 2 MM, 3 SS;
  - group 1 (date): 4 DD, 5 MO, 6 YY;
  - group 2 (timer): 8 HH_T, 9 MM_T, 7 SS_T (left to right, cursor 0..2).
- enUP = edit_mode & btn_up & ~btn_down.
- enDOWN = edit_mode & btn_down & ~btn_up.
- Both buttons held gives neither request.
- enUP and enDOWN are combinational from the button levels (0 latency). Downstream counters sample them on their own slow tick, so no pulse shaping is done here.
- Timeout counter:
  - increments every clock in EDIT;
  - cleared on any prog, left or right edge, or while btn_up or btn_down is high;
  - held at 0 in IDLE.
- Blink:
  - counter runs only in EDIT; blink toggles when the counter reaches BLINK_CYC-1, and the counter then restarts at 0;
  - any cursor move restarts the counter with blink <= 1, so the new field shows immediately;
  - in IDLE, blink = 0 and the counter = 0.
- Exit from EDIT forces en_count, enUP and enDOWN to 0 in the same cycle the state changes. There is no residual request.
- Reset asserted mid-edit: immediate return to IDLE with all outputs 0, independent of clk.

Test Plan:
- Reset, grp_sel=2, btn_prog pulse -> edit_mode=1 the next clock, en_count=8, blink=1.
- In EDIT with group 2: right, right -> en_count 9 then 7; right again -> 8 (wrap); left from 8 -> 7 (wrap).
- With en_count=9, hold btn_up 10 clocks -> enUP=1 throughout, enDOWN=0. Hold up and down together -> both 0. Release up, hold down -> enDOWN=1.
- TIMEOUT_CYC=20, BLINK_CYC=4: idle in EDIT -> exit exactly 20 clocks after the last event, en_count=0. Blink toggles every 4 clocks. A right edge at clock 15 postpones the exit to clock 35.
- Change grp_sel 0->1 during EDIT -> en_count stays in 1..3. Exit via prog, grp_sel=1, re-enter -> en_count=4.
- Assert reset mid-edit with btn_up held -> edit_mode, en_count, enUP and blink all 0 asynchronously. After release, edit mode is not re-entered until a new prog edge.
